// File: rtl/dll_pkg.sv
// Shared data-link-layer constants: DLC state encoding and default receive widths.
package dll_pkg;

  typedef enum logic [1:0] {
    DLC_DL_INACTIVE = 2'b00,
    DLC_DL_FEATURE  = 2'b01,
    DLC_DL_INIT     = 2'b10,
    DLC_DL_ACTIVE   = 2'b11
  } dlc_state_e;

  localparam int DLL_DATA_W = 1196;
  localparam int DLL_DLLP_W = 48;

endpackage

// File: rtl/dll_rx_sync_fifo.sv
// Show-ahead synchronous FIFO with a synchronous flush that empties it in one edge.
module dll_rx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             do_pop, do_push;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q[PTR_W-1:0]] <= din_i;
  end

  // Storage is never reset, so the head is masked to zero while empty.
  assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: rtl/dll_rx_pkt_router.sv
// Receive-side DLLP/TLP router gated by DLC state, one FIFO per class.
// Drop counters exist only when DLL_RX_ROUTER_STATS_EN is defined.
module dll_rx_pkt_router
  import dll_pkg::*;
#(
  parameter int DATA_W     = DLL_DATA_W,
  parameter int DLLP_W     = DLL_DLLP_W,
  parameter int TLP_DEPTH  = 4,
  parameter int DLLP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        dlc_state_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  output logic [DLLP_W-1:0] dllp_o,
  output logic              dllp_valid_o,
  input  logic              dllp_ready_i,
  output logic [DATA_W-1:0] tlp_o,
  output logic              tlp_valid_o,
  input  logic              tlp_ready_i,
  output logic [15:0]       dllp_drop_cnt_o,
  output logic [15:0]       tlp_drop_cnt_o
);

  dlc_state_e dlc_state;
  logic       is_dllp, flush;
  logic       dllp_want, tlp_want;
  logic       dllp_full, dllp_empty, tlp_full, tlp_empty;
  logic       dllp_drop, tlp_drop;

  assign dlc_state = dlc_state_e'(dlc_state_i);
  assign is_dllp   = ~|rx_data_i[DATA_W-1:DLLP_W];
  assign flush     = (dlc_state == DLC_DL_INACTIVE);

  assign dllp_want = rx_valid_i & is_dllp &
                     ((dlc_state == DLC_DL_INIT) | (dlc_state == DLC_DL_ACTIVE));
  assign tlp_want  = rx_valid_i & ~is_dllp & (dlc_state == DLC_DL_ACTIVE);

  // A full FIFO still takes the word when its consumer pops in the same cycle.
  assign dllp_drop = dllp_want & dllp_full & ~dllp_ready_i;
  assign tlp_drop  = tlp_want & tlp_full & ~tlp_ready_i;

  dll_rx_sync_fifo #(.WIDTH(DLLP_W), .DEPTH(DLLP_DEPTH)) u_dllp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (dllp_want),
    .din_i   (rx_data_i[DLLP_W-1:0]),
    .pop_i   (dllp_ready_i),
    .dout_o  (dllp_o),
    .full_o  (dllp_full),
    .empty_o (dllp_empty)
  );

  dll_rx_sync_fifo #(.WIDTH(DATA_W), .DEPTH(TLP_DEPTH)) u_tlp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (tlp_want),
    .din_i   (rx_data_i),
    .pop_i   (tlp_ready_i),
    .dout_o  (tlp_o),
    .full_o  (tlp_full),
    .empty_o (tlp_empty)
  );

  assign dllp_valid_o = ~dllp_empty;
  assign tlp_valid_o  = ~tlp_empty;

`ifdef DLL_RX_ROUTER_STATS_EN
  logic [15:0] dllp_cnt_q, dllp_cnt_d;
  logic [15:0] tlp_cnt_q, tlp_cnt_d;

  always_comb begin
    dllp_cnt_d = dllp_cnt_q;
    tlp_cnt_d  = tlp_cnt_q;
    if (dllp_drop && dllp_cnt_q != 16'hFFFF) dllp_cnt_d = dllp_cnt_q + 16'd1;
    if (tlp_drop && tlp_cnt_q != 16'hFFFF)   tlp_cnt_d  = tlp_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dllp_cnt_q <= '0;
      tlp_cnt_q  <= '0;
    end else begin
      dllp_cnt_q <= dllp_cnt_d;
      tlp_cnt_q  <= tlp_cnt_d;
    end
  end

  assign dllp_drop_cnt_o = dllp_cnt_q;
  assign tlp_drop_cnt_o  = tlp_cnt_q;
`else
  logic stats_unused;
  assign stats_unused    = dllp_drop ^ tlp_drop;
  assign dllp_drop_cnt_o = 16'h0;
  assign tlp_drop_cnt_o  = 16'h0;
`endif

endmodule

// File: doc/dll_rx_pkt_router.md
# dll_rx_pkt_router

Registered, buffered successor to the receive-side packet demultiplexer in the DLCMSM data-link layer. Classifies each incoming link-layer word as a DLLP or a TLP and gates it by Data Link Control state: DLLPs pass in DL_INIT and DL_ACTIVE, TLPs only in DL_ACTIVE. Each class is pushed into its own FIFO with a valid/ready output, so the DLLP handler and the TLP receive path can backpressure independently. Sits between the PHY receive interface and the DLLP/TLP consumers.

## Interface
Parameters:
- DATA_W, 1196: receive word width.
- DLLP_W, 48: DLLP width; DLLP occupies bits [DLLP_W-1:0].
- TLP_DEPTH, 4: TLP FIFO entries; power of 2, ≥2.
- DLLP_DEPTH, 4: DLLP FIFO entries; power of 2, ≥2.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- dlc_state_i  in  2  DLC state: 00 DL_INACTIVE, 01 DL_FEATURE, 10 DL_INIT, 11 DL_ACTIVE.
- rx_data_i  in  DATA_W  receive word.
- rx_valid_i  in  1  word valid this cycle. There is no ready; the PHY cannot be stalled.
- dllp_o  out  DLLP_W  head of DLLP FIFO.
- dllp_valid_o  out  1  DLLP FIFO non-empty.
- dllp_ready_i  in  1  consumer pops DLLP when valid and ready.
- tlp_o  out  DATA_W  head of TLP FIFO.
- tlp_valid_o  out  1  TLP FIFO non-empty.
- tlp_ready_i  in  1  consumer pops TLP when valid and ready.
- dllp_drop_cnt_o  out  16  DLLPs lost to a full FIFO, saturating.
- tlp_drop_cnt_o  out  16  TLPs lost to a full FIFO, saturating.

## Operation
- Classification applies only when rx_valid_i=1:
  - DLLP if rx_data_i[DATA_W-1:DLLP_W]==0; write rx_data_i[DLLP_W-1:0] to the DLLP FIFO.
  - Otherwise TLP; write the full rx_data_i to the TLP FIFO.
- State gating:
  - DLLPs are accepted in DL_INIT and DL_ACTIVE.
  - TLPs are accepted in DL_ACTIVE only.
  - Words rejected by state gating are silently discarded and are not counted.
- Flush: while dlc_state_i==DL_INACTIVE, both FIFOs are held empty (pointers cleared at every edge) and input is discarded. Drop counters are not cleared by a flush.
- Full handling:
  - A write is accepted if the FIFO is not full, or if it is full and popped in the same cycle.
  - Otherwise the word is dropped and the matching counter increments. The counter holds at 16'hFFFF.
- A pop and a write in the same cycle keep the occupancy unchanged. Data stays in order within each class; there is no ordering relation between the classes.
- Each output's data is stable while valid=1 and ready=0.

## Timing
- Reset (async, rst_n=0): FIFOs empty, dllp_valid_o=0, tlp_valid_o=0, dllp_o=0, tlp_o=0, both drop counters=0.
- Latency: a word accepted at edge N appears on the output with valid=1 after edge N. This is one cycle of latency; there is no combinational path from rx_* to outputs.
- FIFO outputs are show-ahead: the head is visible while valid=1, and the next entry appears the cycle after the pop edge.
- A drop counter updates at the edge that rejects the word.
- Flush timing:
  - Entering DL_INACTIVE at cycle N: valid outputs are 0 after edge N.
  - A pop presented in cycle N has no effect beyond the flush.
- Reset asserted mid-operation clears everything immediately, regardless of the clock.

## Configuration
- DLL_RX_ROUTER_STATS_EN
  - Defined: both drop counters are implemented as above.
  - Undefined: no counter flops; dllp_drop_cnt_o and tlp_drop_cnt_o are tied to 16'h0. Drop behaviour itself is unchanged.

## Structure
- Shared package dll_pkg:
  - DLC state constants DLC_DL_INACTIVE, DLC_DL_FEATURE, DLC_DL_INIT, DLC_DL_ACTIVE.
  - Width localparams DLL_DATA_W=1196 and DLL_DLLP_W=48.
- One sub-module, dll_rx_sync_fifo:
  - Parameters WIDTH and DEPTH.
  - Async active-low reset, synchronous flush input.
  - Ports: push, pop, full, empty, show-ahead dout.
  - Instantiated twice.

## Test plan
- DL_ACTIVE, rx_data_i={1148'h0, 48'hA1B2C3D4E5F6}, valid for 1 cycle → dllp_valid_o=1 the next cycle, dllp_o=48'hA1B2C3D4E5F6, tlp_valid_o stays 0.
- DL_INIT, one TLP word (bit 1195=1) followed by one DLLP → TLP discarded (tlp_valid_o=0, tlp_drop_cnt_o=0), DLLP delivered.
- DL_ACTIVE, tlp_ready_i=0, 6 back-to-back TLPs into TLP_DEPTH=4 → 4 buffered, tlp_drop_cnt_o=2. Releasing ready drains the first 4 in order.
- FIFO full with tlp_ready_i=1 and a new TLP in the same cycle → write accepted, no drop, occupancy stays 4.
- DLLP FIFO holding 3 entries, dlc_state_i→DL_INACTIVE for 1 cycle → dllp_valid_o=0 the next cycle. Drop counter unchanged. Back in DL_ACTIVE, a new DLLP arrives as the sole entry.
- 65540 drops with DLL_RX_ROUTER_STATS_EN defined → counter reads 16'hFFFF. Without the macro → reads 16'h0.
